// File: rtl/ps2_key_status_tracker.sv
// Letter-key make/break tracker for decoded PS/2 Set-2 bytes; holds one level per letter A..Z.
// Optional event outputs (event_valid/event_idx/event_make) are enabled by defining KBD_EVENT_OUT_EN.
module ps2_key_status_tracker #(
   parameter int TIMEOUT_CYCLES = 2500000,
   parameter int TMO_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   input  logic        rx_err,
   input  logic        clear,
`ifdef KBD_EVENT_OUT_EN
   output logic        event_valid,
   output logic [4:0]  event_idx,
   output logic        event_make,
`endif
   output logic [25:0] key_status,
   output logic        key_any,
   output logic        proto_err
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_BREAK     = 2'd1,
      S_EXT       = 2'd2,
      S_EXT_BREAK = 2'd3
   } state_t;

   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   state_t            state_reg, state_next;
   logic [25:0]       key_reg, key_next;
   logic              any_reg;
   logic              perr_reg, perr_next;
   logic [TMO_W-1:0]  cnt_reg, cnt_next;
   logic              letter_hit;
   logic [4:0]        letter_idx;

   // Set-2 scan code to letter index
   always_comb begin
      letter_hit = 1'b1;
      letter_idx = 5'd0;
      case (rx_data)
         8'h1C: letter_idx = 5'd0;
         8'h32: letter_idx = 5'd1;
         8'h21: letter_idx = 5'd2;
         8'h23: letter_idx = 5'd3;
         8'h24: letter_idx = 5'd4;
         8'h2B: letter_idx = 5'd5;
         8'h34: letter_idx = 5'd6;
         8'h33: letter_idx = 5'd7;
         8'h43: letter_idx = 5'd8;
         8'h3B: letter_idx = 5'd9;
         8'h42: letter_idx = 5'd10;
         8'h4B: letter_idx = 5'd11;
         8'h3A: letter_idx = 5'd12;
         8'h31: letter_idx = 5'd13;
         8'h44: letter_idx = 5'd14;
         8'h4D: letter_idx = 5'd15;
         8'h15: letter_idx = 5'd16;
         8'h2D: letter_idx = 5'd17;
         8'h1B: letter_idx = 5'd18;
         8'h2C: letter_idx = 5'd19;
         8'h3C: letter_idx = 5'd20;
         8'h2A: letter_idx = 5'd21;
         8'h1D: letter_idx = 5'd22;
         8'h22: letter_idx = 5'd23;
         8'h35: letter_idx = 5'd24;
         8'h1A: letter_idx = 5'd25;
         default: letter_hit = 1'b0;
      endcase
   end

   always_comb begin
      state_next = state_reg;
      key_next   = key_reg;
      perr_next  = 1'b0;
      cnt_next   = cnt_reg;
      if (clear) begin
         key_next   = '0;
         state_next = S_IDLE;
         cnt_next   = '0;
      end else if (rx_valid) begin
         cnt_next = '0;
         if (rx_err) begin
            state_next = S_IDLE;
            perr_next  = 1'b1;
         end else begin
            case (state_reg)
               S_IDLE: begin
                  if (rx_data == 8'hF0)
                     state_next = S_BREAK;
                  else if (rx_data == 8'hE0)
                     state_next = S_EXT;
                  else if (rx_data == 8'hAA)
                     key_next = '0;
                  else if (letter_hit)
                     key_next[letter_idx] = 1'b1;
               end
               S_BREAK: begin
                  if (letter_hit)
                     key_next[letter_idx] = 1'b0;
                  state_next = S_IDLE;
               end
               S_EXT:
                  state_next = (rx_data == 8'hF0) ? S_EXT_BREAK : S_IDLE;
               default:
                  state_next = S_IDLE;
            endcase
         end
      end else if (state_reg != S_IDLE) begin
         // an abandoned prefix is reported like a discarded byte
         if (cnt_reg == TMO_LAST) begin
            state_next = S_IDLE;
            perr_next  = 1'b1;
            cnt_next   = '0;
         end else begin
            cnt_next = cnt_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= S_IDLE;
         key_reg   <= '0;
         any_reg   <= 1'b0;
         perr_reg  <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         key_reg   <= key_next;
         any_reg   <= |key_next;
         perr_reg  <= perr_next;
         cnt_reg   <= cnt_next;
      end
   end

   assign key_status = key_reg;
   assign key_any    = any_reg;
   assign proto_err  = perr_reg;

`ifdef KBD_EVENT_OUT_EN
   logic       ev_valid_reg, ev_valid_next;
   logic       ev_make_reg, ev_make_next;
   logic [4:0] ev_idx_reg;
   logic       byte_ok;

   // only genuine letter transitions produce an event; clear and AA never do
   always_comb begin
      byte_ok       = rx_valid && !rx_err && !clear && letter_hit;
      ev_make_next  = byte_ok && (state_reg == S_IDLE) && (rx_data != 8'hF0) &&
                      (rx_data != 8'hE0) && !key_reg[letter_idx];
      ev_valid_next = ev_make_next ||
                      (byte_ok && (state_reg == S_BREAK) && key_reg[letter_idx]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ev_valid_reg <= 1'b0;
         ev_make_reg  <= 1'b0;
         ev_idx_reg   <= '0;
      end else begin
         ev_valid_reg <= ev_valid_next;
         ev_make_reg  <= ev_make_next;
         ev_idx_reg   <= letter_idx;
      end
   end

   assign event_valid = ev_valid_reg;
   assign event_make  = ev_make_reg;
   assign event_idx   = ev_idx_reg;
`endif

endmodule

// File: tb/tb_ps2_key_status_tracker.sv
// Directed and randomized bench for ps2_key_status_tracker against a per-byte key-table model.
module tb_ps2_key_status_tracker;

   localparam int T = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_err = 1'b0;
   logic        clear = 1'b0;
   logic [25:0] key_status;
   logic        key_any;
   logic        proto_err;
`ifdef KBD_EVENT_OUT_EN
   logic        event_valid;
   logic [4:0]  event_idx;
   logic        event_make;
`endif

   int checks = 0;
   int failures = 0;

   ps2_key_status_tracker #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_err(rx_err), .clear(clear),
`ifdef KBD_EVENT_OUT_EN
      .event_valid(event_valid), .event_idx(event_idx), .event_make(event_make),
`endif
      .key_status(key_status), .key_any(key_any), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   // reference model: held[] per letter, pend = pending prefix (0 none, 1 F0, 2 E0, 3 E0 F0)
   byte unsigned letter_map [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
      8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
      8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
   bit held [26];
   int pend = 0;
   int cyc = 0;
   int last_byte = 0;
   bit exp_perr = 0;
   bit exp_ev = 0;
   bit exp_ev_make = 0;
   int exp_ev_idx = 0;
   int ev_count = 0;
   int perr_count = 0;

   function automatic int lookup(input byte unsigned b);
      for (int i = 0; i < 26; i++)
         if (letter_map[i] == b) return i;
      return -1;
   endfunction

   function automatic logic [25:0] model_vec();
      logic [25:0] v = '0;
      for (int i = 0; i < 26; i++) v[i] = held[i];
      return v;
   endfunction

   task automatic check_outputs();
      logic [25:0] ev = model_vec();
      checks++;
      assert (key_status === ev) else begin
         failures++;
         $error("FAIL key_status cyc=%0d got=%h exp=%h", cyc, key_status, ev);
      end
      checks++;
      assert (key_any === (ev != 0)) else begin
         failures++;
         $error("FAIL key_any cyc=%0d got=%b exp=%b", cyc, key_any, ev != 0);
      end
      checks++;
      assert (proto_err === exp_perr) else begin
         failures++;
         $error("FAIL proto_err cyc=%0d got=%b exp=%b", cyc, proto_err, exp_perr);
      end
`ifdef KBD_EVENT_OUT_EN
      checks++;
      assert (event_valid === exp_ev) else begin
         failures++;
         $error("FAIL event_valid cyc=%0d got=%b exp=%b", cyc, event_valid, exp_ev);
      end
      if (exp_ev) begin
         checks++;
         assert (event_idx === 5'(exp_ev_idx) && event_make === exp_ev_make) else begin
            failures++;
            $error("FAIL event_data cyc=%0d got=%0d/%b exp=%0d/%b", cyc, event_idx,
                   event_make, exp_ev_idx, exp_ev_make);
         end
      end
`endif
   endtask

   task automatic step(input bit r, input bit v, input byte unsigned d, input bit e, input bit c);
      int li;
      reset = r; rx_valid = v; rx_data = d; rx_err = e; clear = c;
      @(posedge clk);
      exp_perr = 0;
      exp_ev = 0;
      if (r) begin
         foreach (held[i]) held[i] = 0;
         pend = 0;
         last_byte = cyc;
      end else if (c) begin
         foreach (held[i]) held[i] = 0;
         pend = 0;
         last_byte = cyc;
      end else if (v) begin
         last_byte = cyc;
         li = lookup(d);
         if (e) begin
            pend = 0;
            exp_perr = 1;
         end else if (pend == 0) begin
            if (d == 8'hF0) pend = 1;
            else if (d == 8'hE0) pend = 2;
            else if (d == 8'hAA) foreach (held[i]) held[i] = 0;
            else if (li >= 0) begin
               if (!held[li]) begin exp_ev = 1; exp_ev_make = 1; exp_ev_idx = li; end
               held[li] = 1;
            end
         end else if (pend == 1) begin
            if (li >= 0) begin
               if (held[li]) begin exp_ev = 1; exp_ev_make = 0; exp_ev_idx = li; end
               held[li] = 0;
            end
            pend = 0;
         end else if (pend == 2) begin
            pend = (d == 8'hF0) ? 3 : 0;
         end else begin
            pend = 0;
         end
      end else if (pend != 0 && cyc - last_byte == T) begin
         pend = 0;
         exp_perr = 1;
      end
      cyc++;
      #1;
      check_outputs();
      if (exp_ev) ev_count++;
      if (proto_err) perr_count++;
      $display("cyc=%0d rst=%b v=%b d=%h err=%b clr=%b -> ks=%h any=%b perr=%b",
               cyc, r, v, d, e, c, key_status, key_any, proto_err);
   endtask

   task automatic send(input byte unsigned d);
      step(0, 1, d, 0, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, 0);
   endtask

   task automatic expect_vec(input string tag, input logic [25:0] exp);
      checks++;
      assert (key_status === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, key_status, exp);
      end
   endtask

   initial begin
      int gap;
      int pick;
      byte unsigned b;

      // reset state
      step(1, 0, 8'h00, 0, 0);
      step(1, 1, 8'h1C, 0, 0);
      expect_vec("reset", 26'h0);

      // W make then break
      send(8'h1D);
      expect_vec("w_make", 26'h0400000);
      send(8'hF0); send(8'h1D);
      expect_vec("w_break", 26'h0);

      // make A, make S, S repeats, break A
      ev_count = 0;
      send(8'h1C); send(8'h1B); send(8'h1B); send(8'h1B); send(8'h1B);
      send(8'hF0); send(8'h1C);
      expect_vec("s_only", 26'h0040000);
`ifdef KBD_EVENT_OUT_EN
      checks++;
      assert (ev_count == 3) else begin
         failures++;
         $error("FAIL event_count got=%0d exp=3", ev_count);
      end
`endif
      send(8'hAA);

      // extended break of A code ignored; E0 75 no change
      send(8'h1C); send(8'hE0); send(8'hF0); send(8'h1C);
      expect_vec("ext_break", 26'h0000001);
      send(8'hE0); send(8'h75); send(8'h1C);
      expect_vec("ext_other", 26'h0000001);
      send(8'hAA);

      // prefix timeout then D make
      perr_count = 0;
      send(8'hF0); idle(T); send(8'h23);
      checks++;
      assert (perr_count == 1) else begin
         failures++;
         $error("FAIL timeout_pulses got=%0d exp=1", perr_count);
      end
      expect_vec("timeout_make", 26'h0000008);

      // byte arriving on the expiry cycle is processed as a break
      send(8'hF0); idle(T - 1); send(8'h23);
      expect_vec("expiry_byte", 26'h0);

      // W and D held, errored byte mid-break, then AA
      send(8'h1D); send(8'h23); send(8'hF0);
      step(0, 1, 8'h1D, 1, 0);
      expect_vec("err_keep", 26'h0400008);
      send(8'h1D);
      expect_vec("err_idle", 26'h0400008);
      send(8'hAA);
      expect_vec("bat_clear", 26'h0);

      // clear beats simultaneous make; reset in E0 F0 prefix
      step(0, 1, 8'h2B, 0, 1);
      expect_vec("clear_wins", 26'h0);
      send(8'h32); send(8'hE0); send(8'hF0);
      step(1, 0, 8'h00, 0, 0);
      send(8'h1C);
      expect_vec("reset_prefix", 26'h0000001);

      // randomized byte stream with gaps around the timeout boundary
      for (int n = 0; n < 300; n++) begin
         gap = ($urandom_range(0, 7) == 0) ? $urandom_range(T - 2, T + 3) : $urandom_range(0, 2);
         idle(gap);
         pick = $urandom_range(0, 19);
         if (pick < 9) b = letter_map[$urandom_range(0, 25)];
         else if (pick < 13) b = 8'hF0;
         else if (pick < 15) b = 8'hE0;
         else if (pick == 15) b = 8'hAA;
         else b = 8'($urandom_range(0, 255));
         step(0, 1, b, $urandom_range(0, 15) == 0, $urandom_range(0, 39) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
